sdram_line_fetcher: RTL and testbench

- Scanout stage between the SDRAM controller wrapper's internal interface and the HDMI/VGA pixel path.
- Reads the framebuffer from SDRAM in fixed-length bursts into a ping-pong pair of line buffers.
- Presents one 16-bit pixel per data-enable cycle to the display path.
- Replaces the on-chip vram for scanout and hides SDRAM latency by prefetching one line ahead.

---
 rtl/sdram_line_fetcher_if.sv | 12 +
 rtl/sdram_line_fetcher.sv | 131 +++++++++++++
 tb/tb_sdram_line_fetcher.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_line_fetcher_if.sv
// Read-only view of the SDRAM controller wrapper bus used by the scanout line fetcher.
interface sdram_line_fetcher_if;
  logic        sc_idle_i;
  logic [31:0] sc_adr_o;
  logic        sc_acc_o;
  logic        sc_we_o;
  logic        sc_ack_i;
  logic [15:0] sc_dat_i;

  modport master (input sc_idle_i, sc_ack_i, sc_dat_i, output sc_adr_o, sc_acc_o, sc_we_o);
  modport slave  (output sc_idle_i, sc_ack_i, sc_dat_i, input sc_adr_o, sc_acc_o, sc_we_o);
endinterface

// File: rtl/sdram_line_fetcher.sv
// Scanout line fetcher: bursts framebuffer lines from SDRAM into a ping-pong line
// buffer one line ahead of the display and streams one pixel per data-enable cycle.
module sdram_line_fetcher #(
  parameter int          FB_WIDTH     = 128,
  parameter int          FB_HEIGHT    = 128,
  parameter int          BURST_LEN    = 8,
  parameter logic [31:0] BASE_ADDR    = 32'd0,
  parameter logic [15:0] BORDER_COLOR = 16'h0222
) (
  input  logic                        clk,
  input  logic                        reset_i,
  input  logic                        frame_i,
  input  logic                        swap_i,
  input  logic                        de_i,
  output logic [15:0]                 pixel_o,
  output logic                        pixel_valid_o,
  output logic                        underflow_o,
  sdram_line_fetcher_if.master        bus
);
  localparam int XW = $clog2(FB_WIDTH);
  localparam int LW = $clog2(FB_HEIGHT + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [XW:0]   WIDTH_W    = (XW+1)'(FB_WIDTH);
  localparam logic [LW-1:0] LAST_LINE  = LW'(FB_HEIGHT - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

  state_t        state;
  logic          fill_bank, line_valid, discard;
  logic [LW-1:0] fetch_line;
  logic [XW:0]   word_idx, x;
  logic [BW-1:0] ack_cnt;
  logic [15:0]   bank [2*FB_WIDTH];
  logic          last_ack, wr_en;

  assign last_ack    = bus.sc_ack_i && (ack_cnt == BURST_LAST);
  // Data of a burst overtaken by a new frame must not land in the fresh bank.
  assign wr_en       = (state == BURST) && bus.sc_ack_i && !discard && !frame_i;
  assign bus.sc_we_o = 1'b0;

  always_ff @(posedge clk)
    if (wr_en) bank[{fill_bank, word_idx[XW-1:0]}] <= bus.sc_dat_i;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      fill_bank    <= 1'b0;
      line_valid   <= 1'b0;
      discard      <= 1'b0;
      fetch_line   <= '0;
      word_idx     <= '0;
      ack_cnt      <= '0;
      underflow_o  <= 1'b0;
      bus.sc_acc_o <= 1'b0;
      bus.sc_adr_o <= '0;
    end else begin
      underflow_o <= 1'b0;
      if (state == BURST && bus.sc_ack_i) begin
        word_idx <= word_idx + 1'b1;
        ack_cnt  <= ack_cnt + 1'b1;
        if (last_ack) begin
          bus.sc_acc_o <= 1'b0;
          ack_cnt      <= '0;
          discard      <= 1'b0;
          if (discard) begin
            state    <= REQ;
            word_idx <= '0;
          end else begin
            state <= (word_idx + 1'b1 == WIDTH_W) ? DONE : REQ;
          end
        end
      end
      if (state == REQ && bus.sc_idle_i) begin
        bus.sc_adr_o <= BASE_ADDR + 32'(fetch_line) * 32'(FB_WIDTH) + 32'(word_idx);
        bus.sc_acc_o <= 1'b1;
        state        <= BURST;
      end
      if (swap_i && !frame_i) begin
        case (state)
          DONE: begin
            fill_bank  <= ~fill_bank;
            line_valid <= 1'b1;
            if (fetch_line < LAST_LINE) begin
              fetch_line <= fetch_line + 1'b1;
              word_idx   <= '0;
              state      <= REQ;
            end else begin
              state <= IDLE;
            end
          end
          IDLE:    line_valid <= 1'b0;
          default: begin
            underflow_o <= 1'b1;
            line_valid  <= 1'b0;
          end
        endcase
      end
      // A burst in flight must finish on the bus; the restart follows its last ack.
      if (frame_i) begin
        fetch_line <= '0;
        fill_bank  <= 1'b0;
        line_valid <= 1'b0;
        if (state == BURST && !last_ack) begin
          discard <= 1'b1;
        end else begin
          state        <= REQ;
          word_idx     <= '0;
          discard      <= 1'b0;
          bus.sc_acc_o <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      x             <= '0;
      pixel_o       <= '0;
      pixel_valid_o <= 1'b0;
    end else begin
      pixel_valid_o <= de_i;
      if (swap_i)                      x <= '0;
      else if (de_i && x != WIDTH_W)   x <= x + 1'b1;
      if (!de_i)                       pixel_o <= '0;
      else if (line_valid && x < WIDTH_W)
        pixel_o <= bank[{~fill_bank, x[XW-1:0]}];
      else                             pixel_o <= BORDER_COLOR;
    end
  end
endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Bench for sdram_line_fetcher: SDRAM controller model returning word = address,
// a line-level scanout model, and a per-cycle compare of pixel/valid/underflow.
module tb_sdram_line_fetcher;
  localparam int          W = 128, H = 128, BL = 8;
  localparam logic [31:0] BASE   = 32'd0;
  localparam logic [15:0] BORDER = 16'h0222;

  logic clk = 0, rst = 0, frame = 0, swap = 0, de = 0;
  logic [15:0] pixel;
  logic        pixel_valid, underflow;

  sdram_line_fetcher_if sif();
  sdram_line_fetcher #(.FB_WIDTH(W), .FB_HEIGHT(H), .BURST_LEN(BL),
                       .BASE_ADDR(BASE), .BORDER_COLOR(BORDER)) dut (
    .clk(clk), .reset_i(rst), .frame_i(frame), .swap_i(swap), .de_i(de),
    .pixel_o(pixel), .pixel_valid_o(pixel_valid), .underflow_o(underflow), .bus(sif));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller model state
  int          c_lat = 2, c_wait = 0, c_k = 0, req_count = 0;
  bit          c_busy = 0, c_armed = 1;
  logic [31:0] c_adr = 0, last_req_adr = 0;
  logic [31:0] req_log[$];

  // Scanout model state
  int          m_line = 0, m_words = 0, m_disp = -1, m_x = 0, m_discard = 0, uf_count = 0;
  bit          m_active = 0, chk_en = 0;
  logic [15:0] e_pix = 0;
  logic        e_vld = 0, e_uf = 0;
  logic [15:0] cap[$];

  initial begin
    sif.sc_idle_i = 1; sif.sc_ack_i = 0; sif.sc_dat_i = 0;
    forever begin
      @(negedge clk);
      sif.sc_ack_i = 0;
      if (rst) begin
        c_busy = 0; c_armed = 1; sif.sc_idle_i = 1;
      end else begin
        if (c_busy) check("acc_held", {31'd0, sif.sc_acc_o}, 1);
        check("we_zero", {31'd0, sif.sc_we_o}, 0);
        if (!c_busy) begin
          if (sif.sc_acc_o && c_armed) begin
            c_busy = 1; c_armed = 0; c_adr = sif.sc_adr_o; c_wait = c_lat; c_k = 0;
            req_count++; last_req_adr = c_adr; req_log.push_back(c_adr);
            check("req_allowed", {31'd0, m_active}, 1);
            check("req_adr", c_adr, BASE + 32'(m_line) * W + 32'(m_words));
          end else if (!sif.sc_acc_o) c_armed = 1;
        end else if (c_wait > 0) c_wait--;
        else begin
          sif.sc_ack_i = 1;
          sif.sc_dat_i = c_adr[15:0] + 16'(c_k);
          c_k++;
          if (c_k == BL) c_busy = 0;
        end
        sif.sc_idle_i = !c_busy;
      end
    end
  end

  // Line-level model: a swap shows the completed line, else border (+underflow if mid-fetch).
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_line = 0; m_words = 0; m_disp = -1; m_x = 0; m_discard = 0; m_active = 0;
        e_pix = 0; e_vld = 0; e_uf = 0;
      end else begin
        if (de) begin
          e_pix = (m_disp >= 0 && m_x < W) ? 16'(BASE + 32'(m_disp) * W + 32'(m_x)) : BORDER;
          e_vld = 1;
          if (m_x < W) m_x++;
        end else begin
          e_pix = 0; e_vld = 0;
        end
        e_uf = 0;
        if (frame) begin
          m_line = 0; m_words = 0; m_active = 1; m_disp = -1;
          m_discard = c_busy ? BL - c_k : 0;
        end else begin
          if (swap) begin
            m_x = 0;
            if (m_active && m_words == W) begin
              m_disp = m_line;
              if (m_line < H - 1) begin m_line++; m_words = 0; end
              else m_active = 0;
            end else if (!m_active) m_disp = -1;
            else begin m_disp = -1; e_uf = 1; end
          end
          if (sif.sc_ack_i) begin
            if (m_discard > 0) m_discard--;
            else m_words++;
          end
        end
      end
      #1;
      if (chk_en && !rst) begin
        check("pixel", {16'd0, pixel}, {16'd0, e_pix});
        check("pixel_valid", {31'd0, pixel_valid}, {31'd0, e_vld});
        check("underflow", {31'd0, underflow}, {31'd0, e_uf});
        if (pixel_valid) cap.push_back(pixel);
        if (underflow) uf_count++;
      end
    end
  end

  task automatic show_line(input int nde, input int blank);
    @(negedge clk); swap = 1;
    @(negedge clk); swap = 0; cap.delete();
    repeat (nde) begin de = 1; @(negedge clk); end
    de = 0;
    repeat (blank) @(negedge clk);
  endtask

  task automatic pulse_frame;
    @(negedge clk); frame = 1;
    @(negedge clk); frame = 0;
  endtask

  initial begin
    #1 rst = 1;
    #1;
    check("rst_pixel", {16'd0, pixel}, 0);
    check("rst_valid", {31'd0, pixel_valid}, 0);
    check("rst_uf", {31'd0, underflow}, 0);
    check("rst_acc", {31'd0, sif.sc_acc_o}, 0);
    check("rst_we", {31'd0, sif.sc_we_o}, 0);
    check("rst_adr", sif.sc_adr_o, 0);
    repeat (3) @(negedge clk);
    rst = 0; chk_en = 1;

    // Test 1: line 0 fetch and display
    pulse_frame;
    repeat (400) @(negedge clk);
    check("t1_req_count", req_count, 16);
    check("t1_first_adr", req_log[0], 0);
    check("t1_last_adr", last_req_adr, 120);
    show_line(640, 160);
    check("t1_cap_size", cap.size(), 640);
    check("t1_px0", {16'd0, cap[0]}, 0);
    check("t1_px127", {16'd0, cap[127]}, 127);
    check("t1_px128", {16'd0, cap[128]}, {16'd0, BORDER});
    check("t1_px639", {16'd0, cap[639]}, {16'd0, BORDER});
    check("t1_fill_bank", {31'd0, dut.fill_bank}, 1);

    // Test 2: second line
    show_line(640, 160);
    check("t2_px0", {16'd0, cap[0]}, 128);
    check("t2_px127", {16'd0, cap[127]}, 255);
    check("t2_fill_bank", {31'd0, dut.fill_bank}, 0);

    // Test 3: delayed fetch of line 3 -> underflow, border line, then shifted line
    c_lat = 1000;
    show_line(640, 160);
    c_lat = 2;
    check("t3_line2_px0", {16'd0, cap[0]}, 256);
    show_line(640, 160);
    check("t3_uf_count", uf_count, 1);
    check("t3_border0", {16'd0, cap[0]}, {16'd0, BORDER});
    check("t3_border127", {16'd0, cap[127]}, {16'd0, BORDER});
    repeat (600) @(negedge clk);
    show_line(640, 160);
    check("t3_shifted_px0", {16'd0, cap[0]}, 384);
    check("t3_uf_once", uf_count, 1);

    // Test 4: a whole frame of 130 swaps on short lines
    pulse_frame;
    begin
      int base_req;
      base_req = req_count;
      repeat (300) @(negedge clk);
      for (int s = 1; s <= 130; s++) begin
        show_line(136, 120);
        if (s <= 128) check("t4_line_px0", {16'd0, cap[0]}, 32'((s - 1) * W) & 32'hffff);
        else          check("t4_border", {16'd0, cap[0]}, {16'd0, BORDER});
      end
      check("t4_req_total", req_count - base_req, 2048);
      check("t4_uf", uf_count, 1);
    end

    // Test 5: frame during the 4th ack of the burst at address 16
    pulse_frame;
    begin
      bit found;
      int n0;
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
        @(negedge clk); #1;
        if (sif.sc_ack_i && c_k == 4 && c_adr == 16) found = 1;
      end
      check("t5_found", {31'd0, found}, 1);
      frame = 1;
      @(negedge clk); #1 frame = 0;
      n0 = req_count;
      for (int i = 0; i < 100 && req_count == n0; i++) @(negedge clk);
      check("t5_new_req", {31'd0, req_count > n0}, 1);
      check("t5_restart_adr", last_req_adr, BASE);
    end

    // Test 6: asynchronous reset in the middle of a burst
    begin
      for (int i = 0; i < 100 && !c_busy; i++) begin @(negedge clk); #1; end
      check("t6_busy", {31'd0, c_busy}, 1);
      swap = 1; de = 1;
      @(posedge clk); #2;
      check("t6_pre_acc", {31'd0, sif.sc_acc_o}, 1);
      check("t6_pre_valid", {31'd0, pixel_valid}, 1);
      check("t6_pre_uf", {31'd0, underflow}, 1);
      rst = 1;
      #1;
      check("t6_acc", {31'd0, sif.sc_acc_o}, 0);
      check("t6_valid", {31'd0, pixel_valid}, 0);
      check("t6_uf", {31'd0, underflow}, 0);
      check("t6_adr", sif.sc_adr_o, 0);
      swap = 0; de = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      begin
        int n0;
        n0 = req_count;
        repeat (20) @(negedge clk);
        check("t6_post_acc", {31'd0, sif.sc_acc_o}, 0);
        check("t6_no_req", req_count, n0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
